// File: rtl/hwpe_stream_tx_gen_pkg.sv
// hwpe_stream_tx_gen_pkg: shared types and constants for the HWPE-Stream packet generator.
package hwpe_stream_tx_gen_pkg;

    typedef enum logic {
        TX_INCR = 1'b0,
        TX_LFSR = 1'b1
    } tx_mode_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_RUN,
        TX_GAP,
        TX_DONE
    } tx_state_t;

    localparam logic [31:0] DEFAULT_LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/hwpe_stream_tx_gen_if.sv
// hwpe_stream_tx_gen_if: HWPE-Stream beat bundle (valid/ready/data/strb) with source and sink views.
interface hwpe_stream_tx_gen_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport master(output valid, data, strb, input ready);
    modport slave(input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_tx_gen_pattern.sv
// hwpe_stream_tx_gen_pattern: beat data register; loads the seed, then steps INCR or Galois LFSR on each enable.
module hwpe_stream_tx_gen_pattern
    import hwpe_stream_tx_gen_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] LFSR_POLY  = DATA_WIDTH'(DEFAULT_LFSR_POLY)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    input  tx_mode_t              mode_i,
    output logic [DATA_WIDTH-1:0] data_o
);
    tx_mode_t              mode;
    logic [DATA_WIDTH-1:0] next;

    always_comb next = mode == TX_LFSR ? (data_o >> 1) ^ (data_o[0] ? LFSR_POLY : '0) : data_o + DATA_WIDTH'(1);

    // An all-zero LFSR state would lock up, so a zero seed starts from 1 instead
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o <= '0;
            mode   <= TX_INCR;
        end else if (clear_i) begin
            data_o <= '0;
            mode   <= TX_INCR;
        end else if (load_i) begin
            mode   <= mode_i;
            data_o <= (mode_i == TX_LFSR && seed_i == '0) ? DATA_WIDTH'(1) : seed_i;
        end else if (en_i) begin
            data_o <= next;
        end
    end
endmodule

// File: rtl/hwpe_stream_tx_gen.sv
// hwpe_stream_tx_gen: emits a packet of len_i HWPE-Stream beats on start_i, then pulses done_o.
// Define HWPE_STREAM_TX_THROTTLE_EN to add gap_i idle cycles between beats.
module hwpe_stream_tx_gen
    import hwpe_stream_tx_gen_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           LEN_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] LFSR_POLY  = DATA_WIDTH'(DEFAULT_LFSR_POLY)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    input  tx_mode_t              mode_i,
`ifdef HWPE_STREAM_TX_THROTTLE_EN
    input  logic [3:0]            gap_i,
`endif
    output logic                  busy_o,
    output logic                  done_o,
    hwpe_stream_tx_gen_if.master  tx
);
    tx_state_t               state;
    logic [LEN_WIDTH-1:0]    cnt;
    logic [LEN_WIDTH-1:0]    len_q;
    logic                    valid;
    logic [DATA_WIDTH/8-1:0] strb;
    logic                    hs;
    logic                    last;
    logic                    load;
`ifdef HWPE_STREAM_TX_THROTTLE_EN
    logic [3:0]              gap_q;
    logic [3:0]              gap_cnt;
`endif

    assign hs       = valid & tx.ready;
    assign last     = cnt == len_q - LEN_WIDTH'(1);
    assign load     = state == TX_IDLE && start_i && len_i != '0;
    assign tx.valid = valid;
    assign tx.strb  = strb;

    hwpe_stream_tx_gen_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .LFSR_POLY  (LFSR_POLY)
    ) i_pattern (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .load_i  (load),
        .en_i    (hs),
        .seed_i  (seed_i),
        .mode_i  (mode_i),
        .data_o  (tx.data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= TX_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            valid  <= 1'b0;
            strb   <= '0;
            cnt    <= '0;
            len_q  <= '0;
`ifdef HWPE_STREAM_TX_THROTTLE_EN
            gap_q   <= '0;
            gap_cnt <= '0;
`endif
        end else if (clear_i) begin
            state  <= TX_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            valid  <= 1'b0;
            strb   <= '0;
            cnt    <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                TX_IDLE: if (start_i) begin
                    busy_o <= 1'b1;
                    len_q  <= len_i;
                    cnt    <= '0;
`ifdef HWPE_STREAM_TX_THROTTLE_EN
                    gap_q  <= gap_i;
`endif
                    if (len_i != '0) begin
                        state <= TX_RUN;
                        valid <= 1'b1;
                        strb  <= '1;
                    end else begin
                        state  <= TX_DONE;
                        done_o <= 1'b1;
                    end
                end
                TX_RUN: if (hs) begin
                    if (last) begin
                        state  <= TX_DONE;
                        valid  <= 1'b0;
                        strb   <= '0;
                        done_o <= 1'b1;
                    end else begin
                        cnt <= cnt + LEN_WIDTH'(1);
`ifdef HWPE_STREAM_TX_THROTTLE_EN
                        if (gap_q != '0) begin
                            state   <= TX_GAP;
                            valid   <= 1'b0;
                            strb    <= '0;
                            gap_cnt <= gap_q;
                        end
`endif
                    end
                end
`ifdef HWPE_STREAM_TX_THROTTLE_EN
                // Valid reappears on the cycle after the counter reaches one, giving exactly gap_q idle cycles
                TX_GAP: if (gap_cnt == 4'd1) begin
                    state <= TX_RUN;
                    valid <= 1'b1;
                    strb  <= '1;
                end else begin
                    gap_cnt <= gap_cnt - 4'd1;
                end
`endif
                TX_DONE: begin
                    state  <= TX_IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= TX_IDLE;
            endcase
        end
    end
endmodule
